// File: rtl/sata_pkg.sv
// Shared SATA primitive constants and small helpers for the TX rate adapter.
// Fill words are defined per 4-byte group and replicated across wider datapaths.
package sata_pkg;

    localparam logic [31:0] ALIGN_DATA = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_CTRL = 4'b0001;
    localparam logic [31:0] SYNC_DATA  = 32'hB5B5957C;
    localparam logic [3:0]  SYNC_CTRL  = 4'b0001;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int log2ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Byte of a 4-byte primitive that lands on a given lane of a wider word.
    function automatic logic [7:0] fill_byte(input logic [31:0] word, input int lane);
        return word[8*(lane % 4) +: 8];
    endfunction

    function automatic logic fill_kflag(input logic [3:0] kmask, input int lane);
        return kmask[lane % 4];
    endfunction

endpackage

// File: rtl/sata_tx_slot_gen.sv
// Slot timing for the TX rate adapter: tracks the active generation, the
// per-word slot counter and the settle window after reset or a rate change.
module sata_tx_slot_gen
    import sata_pkg::*;
#(
    parameter int GENS          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       tx_clkout,
    input  logic       tx_reset,
    input  logic [1:0] sata_gen,
    output logic       slot,
    output logic       settle_active,
    output logic       gen_change,
    output logic       settling,
    output logic       in_ready
);

    localparam int CNT_W = max_int(1, log2ceil(1 << (GENS - 1)));
    localparam int SET_W = max_int(1, log2ceil(SETTLE_CYCLES + 1));

    logic [1:0]       gen_reg;
    logic [1:0]       gen_clamped;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] ratio_m1;
    logic [SET_W-1:0] settle_reg;
    logic [SET_W-1:0] settle_next;
    int               shift_amt;

    always_comb begin
        if (int'(sata_gen) >= GENS) begin
            gen_clamped = 2'(GENS - 1);
        end else begin
            gen_clamped = sata_gen;
        end
    end

    assign gen_change = (gen_clamped != gen_reg);

    // Slot period is 2**(GENS-1-gen); the counter wraps at period-1.
    always_comb begin
        shift_amt = GENS - 1 - int'(gen_reg);
        ratio_m1  = CNT_W'((1 << shift_amt) - 1);
    end

    assign settle_active = (settle_reg != '0);
    assign slot          = (cnt_reg == '0) & ~settle_active & ~gen_change;
    assign settling      = settle_active | gen_change;
    assign in_ready      = slot & ~tx_reset;

    always_comb begin
        cnt_next    = cnt_reg;
        settle_next = settle_reg;
        if (gen_change) begin
            cnt_next    = '0;
            settle_next = SET_W'(SETTLE_CYCLES);
        end else if (settle_active) begin
            cnt_next    = '0;
            settle_next = settle_reg - SET_W'(1);
        end else if (cnt_reg == ratio_m1) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge tx_clkout) begin
        if (tx_reset) begin
            gen_reg    <= gen_clamped;
            cnt_reg    <= '0;
            settle_reg <= SET_W'(SETTLE_CYCLES);
        end else begin
            gen_reg    <= gen_clamped;
            cnt_reg    <= cnt_next;
            settle_reg <= settle_next;
        end
    end

endmodule

// File: rtl/sata_tx_rate_adapter.sv
// TX generation rate adapter: presents one word per transceiver slot, inserts
// fill primitives on underrun and during the settle window after a rate change.
module sata_tx_rate_adapter
    import sata_pkg::*;
#(
    parameter int          BYTES         = 4,
    parameter int          GENS          = 3,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [31:0] FILL_DATA     = ALIGN_DATA,
    parameter logic [3:0]  FILL_CTRL     = ALIGN_CTRL,
    parameter int          UNDERRUN_BITS = 16
) (
    input  logic                     tx_clkout,
    input  logic                     tx_reset,
    input  logic [1:0]               sata_gen,
    input  logic [8*BYTES-1:0]       in_data,
    input  logic [BYTES-1:0]         in_ctrl,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [8*BYTES-1:0]       tx_dataout,
    output logic [BYTES-1:0]         tx_ctrlout,
    output logic                     slot_strobe,
    output logic                     underrun,
    output logic [UNDERRUN_BITS-1:0] underrun_count,
    output logic                     settling
);

    logic [8*BYTES-1:0]       fill_data;
    logic [BYTES-1:0]         fill_ctrl;

    logic                     slot;
    logic                     settle_active;
    logic                     gen_change;

    logic [8*BYTES-1:0]       data_reg,      data_next;
    logic [BYTES-1:0]         ctrl_reg,      ctrl_next;
    logic                     strobe_reg,    strobe_next;
    logic                     underrun_reg,  underrun_next;
    logic [UNDERRUN_BITS-1:0] count_reg,     count_next;
    // Set while the output already carries a settle fill, so a settle run strobes once.
    logic                     fill_hold_reg, fill_hold_next;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_fill
            assign fill_data[8*gi +: 8] = fill_byte(FILL_DATA, gi);
            assign fill_ctrl[gi]        = fill_kflag(FILL_CTRL, gi);
        end
    endgenerate

    sata_tx_slot_gen #(
        .GENS          (GENS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_slot_gen (
        .tx_clkout     (tx_clkout),
        .tx_reset      (tx_reset),
        .sata_gen      (sata_gen),
        .slot          (slot),
        .settle_active (settle_active),
        .gen_change    (gen_change),
        .settling      (settling),
        .in_ready      (in_ready)
    );

    always_comb begin
        data_next      = data_reg;
        ctrl_next      = ctrl_reg;
        strobe_next    = 1'b0;
        underrun_next  = 1'b0;
        count_next     = count_reg;
        fill_hold_next = fill_hold_reg;
        if (gen_change) begin
            data_next      = fill_data;
            ctrl_next      = fill_ctrl;
            strobe_next    = 1'b1;
            fill_hold_next = 1'b1;
        end else if (settle_active) begin
            data_next      = fill_data;
            ctrl_next      = fill_ctrl;
            strobe_next    = ~fill_hold_reg;
            fill_hold_next = 1'b1;
        end else if (slot) begin
            strobe_next    = 1'b1;
            fill_hold_next = 1'b0;
            if (in_valid) begin
                data_next = in_data;
                ctrl_next = in_ctrl;
            end else begin
                data_next     = fill_data;
                ctrl_next     = fill_ctrl;
                underrun_next = 1'b1;
                if (count_reg != {UNDERRUN_BITS{1'b1}}) begin
                    count_next = count_reg + UNDERRUN_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge tx_clkout) begin
        if (tx_reset) begin
            data_reg      <= fill_data;
            ctrl_reg      <= fill_ctrl;
            strobe_reg    <= 1'b0;
            underrun_reg  <= 1'b0;
            count_reg     <= '0;
            fill_hold_reg <= 1'b1;
        end else begin
            data_reg      <= data_next;
            ctrl_reg      <= ctrl_next;
            strobe_reg    <= strobe_next;
            underrun_reg  <= underrun_next;
            count_reg     <= count_next;
            fill_hold_reg <= fill_hold_next;
        end
    end

    assign tx_dataout     = data_reg;
    assign tx_ctrlout     = ctrl_reg;
    assign slot_strobe    = strobe_reg;
    assign underrun       = underrun_reg;
    assign underrun_count = count_reg;

endmodule

// File: tb/tb_sata_tx_rate_adapter.sv
// Scoreboard bench for sata_tx_rate_adapter: a slot-timing model predicts each
// newly loaded word; a monitor pops and compares on every slot_strobe.
module tb_sata_tx_rate_adapter;

    localparam int          BYTES  = 4;
    localparam int          GENS   = 3;
    localparam int          SETTLE = 4;
    localparam int          UB     = 4;
    localparam logic [31:0] FILL_D = 32'h7B4A4ABC;
    localparam logic [3:0]  FILL_C = 4'b0001;

    logic              tx_clkout = 1'b0;
    logic              tx_reset;
    logic [1:0]        sata_gen;
    logic [31:0]       in_data;
    logic [3:0]        in_ctrl;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       tx_dataout;
    logic [3:0]        tx_ctrlout;
    logic              slot_strobe;
    logic              underrun;
    logic [UB-1:0]     underrun_count;
    logic              settling;

    always #5 tx_clkout = ~tx_clkout;

    sata_tx_rate_adapter #(
        .BYTES         (BYTES),
        .GENS          (GENS),
        .SETTLE_CYCLES (SETTLE),
        .FILL_DATA     (FILL_D),
        .FILL_CTRL     (FILL_C),
        .UNDERRUN_BITS (UB)
    ) dut (
        .tx_clkout      (tx_clkout),
        .tx_reset       (tx_reset),
        .sata_gen       (sata_gen),
        .in_data        (in_data),
        .in_ctrl        (in_ctrl),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .tx_dataout     (tx_dataout),
        .tx_ctrlout     (tx_ctrlout),
        .slot_strobe    (slot_strobe),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .settling       (settling)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  ctrl;
        logic        und;
        logic [UB-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    bit   done     = 1'b0;

    // Reference model: generation, remaining settle cycles, cycles since the window ended.
    int          m_gen    = 2;
    int          m_settle = SETTLE;
    int          m_since  = 0;
    bit          m_fill   = 1'b1;
    int          m_count  = 0;
    int          word_id  = 1;
    logic [31:0] word_data;
    logic [3:0]  word_ctrl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_word();
        logic [3:0] nib;
        if (word_id <= 15) begin
            nib       = word_id[3:0];
            word_data = {8{nib}};
            word_ctrl = 4'b0000;
        end else begin
            word_data = $urandom;
            word_ctrl = 4'($urandom_range(0, 15));
        end
        word_id++;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] c, input logic u);
        exp_t e;
        e.data = d;
        e.ctrl = c;
        e.und  = u;
        e.cnt  = UB'(m_count);
        sb.push_back(e);
    endtask

    task automatic step(input bit rst, input int gen, input bit valid);
        int clamped;
        int ratio;
        bit gc;
        bit slot_now;
        @(negedge tx_clkout);
        tx_reset = rst;
        sata_gen = gen[1:0];
        in_valid = valid;
        in_data  = word_data;
        in_ctrl  = word_ctrl;
        #1;
        clamped = (gen >= GENS) ? GENS - 1 : gen;
        gc      = (clamped != m_gen);
        if (rst) begin
            check("in_ready_in_reset", 64'(in_ready), 64'(0));
            m_gen    = clamped;
            m_settle = SETTLE;
            m_since  = 0;
            m_fill   = 1'b1;
            m_count  = 0;
        end else begin
            ratio    = 1 << (GENS - 1 - m_gen);
            slot_now = !gc && (m_settle == 0) && ((m_since % ratio) == 0);
            check("in_ready", 64'(in_ready), 64'(slot_now));
            check("settling", 64'(settling), 64'((m_settle != 0) || gc));
            if (gc) begin
                push(FILL_D, FILL_C, 1'b0);
                m_gen    = clamped;
                m_settle = SETTLE;
                m_since  = 0;
                m_fill   = 1'b1;
            end else if (m_settle > 0) begin
                if (!m_fill) push(FILL_D, FILL_C, 1'b0);
                m_fill = 1'b1;
                m_settle--;
            end else begin
                if (slot_now) begin
                    m_fill = 1'b0;
                    if (valid) begin
                        push(word_data, word_ctrl, 1'b0);
                        new_word();
                    end else begin
                        if (m_count < (1 << UB) - 1) m_count++;
                        push(FILL_D, FILL_C, 1'b1);
                    end
                end
                m_since++;
            end
        end
    endtask

    // Monitor: compares every strobed word against the scoreboard, checks hold otherwise.
    initial begin
        logic [31:0] held_d;
        logic [3:0]  held_c;
        exp_t        e;
        held_d = FILL_D;
        held_c = FILL_C;
        while (!done) begin
            @(posedge tx_clkout);
            #1;
            if (tx_reset) begin
                check("reset_strobe", 64'(slot_strobe), 64'(0));
                check("reset_underrun", 64'(underrun), 64'(0));
                check("reset_count", 64'(underrun_count), 64'(0));
                check("reset_data", 64'(tx_dataout), 64'(FILL_D));
                held_d = FILL_D;
                held_c = FILL_C;
            end else if (slot_strobe) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe actual=%h required=none at %0t", tx_dataout, $time);
                end else begin
                    e = sb.pop_front();
                    check("word_data", 64'(tx_dataout), 64'(e.data));
                    check("word_ctrl", 64'(tx_ctrlout), 64'(e.ctrl));
                    check("underrun_pulse", 64'(underrun), 64'(e.und));
                    check("underrun_count", 64'(underrun_count), 64'(e.cnt));
                    n_txn++;
                    $display("txn %0d data=%h ctrl=%h underrun=%0d count=%0d",
                             n_txn, tx_dataout, tx_ctrlout, underrun, underrun_count);
                    held_d = e.data;
                    held_c = e.ctrl;
                end
            end else begin
                check("hold_data", 64'(tx_dataout), 64'(held_d));
                check("hold_ctrl", 64'(tx_ctrlout), 64'(held_c));
                check("no_underrun", 64'(underrun), 64'(0));
            end
        end
    end

    initial begin
        int g;
        tx_reset = 1'b1;
        sata_gen = 2'd2;
        in_valid = 1'b0;
        new_word();
        in_data  = word_data;
        in_ctrl  = word_ctrl;

        // Reset release at native rate with a continuous source.
        repeat (3) step(1'b1, 2, 1'b1);
        repeat (12) step(1'b0, 2, 1'b1);
        // Slowest generation.
        repeat (24) step(1'b0, 0, 1'b1);
        // Middle generation with a gap covering one slot.
        for (int i = 0; i < 30; i++) step(1'b0, 1, !(i == 14 || i == 15));
        // Mid-stream change 2 -> 0.
        repeat (10) step(1'b0, 2, 1'b1);
        repeat (20) step(1'b0, 0, 1'b1);
        // Out-of-range generation clamps to native.
        repeat (6) step(1'b0, 2, 1'b1);
        repeat (15) step(1'b0, 3, 1'b1);
        // Saturate the underrun counter, then reset clears it.
        repeat (30) step(1'b0, 2, 1'b0);
        repeat (2) step(1'b1, 2, 1'b0);
        repeat (8) step(1'b0, 2, 1'b1);
        // Randomized traffic with occasional generation changes and resets.
        g = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) g = $urandom_range(0, 3);
            step(($urandom_range(0, 99) == 0), g, ($urandom_range(0, 3) != 0));
        end
        repeat (12) step(1'b0, g, 1'b1);

        done = 1'b1;
        @(negedge tx_clkout);
        @(negedge tx_clkout);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
